// File: rtl/traffic_phase_ctrl_if.sv
// Bundles the run controls, green-time config port, demand inputs and lamp
// outputs of traffic_phase_ctrl.
//   master: drives en, mode, cfg_we, cfg_phase, cfg_green, req; reads lamp,
//           active_phase, phase_start
//   slave : the controller side (mirror of master)
interface traffic_phase_ctrl_if #(
    parameter int unsigned NUM_PH = 4,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned PH_W = $clog2(NUM_PH);

    logic                  en;
    logic [1:0]            mode;
    logic                  cfg_we;
    logic [PH_W-1:0]       cfg_phase;
    logic [CNT_W-1:0]      cfg_green;
    logic [NUM_PH-1:0]     req;
    logic [3*NUM_PH-1:0]   lamp;
    logic [PH_W-1:0]       active_phase;
    logic                  phase_start;

    modport master (
        output en, mode, cfg_we, cfg_phase, cfg_green, req,
        input  lamp, active_phase, phase_start
    );

    modport slave (
        input  en, mode, cfg_we, cfg_phase, cfg_green, req,
        output lamp, active_phase, phase_start
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection signal controller. Each phase runs
// ALLRED -> GREEN -> YELLOW; flash and all-red hold modes are reached through
// a forced yellow/all-red clearance. Timing is in prescaled ticks.
// Ports:
//   clk   - system clock
//   rst_  - asynchronous active-low reset
//   bus   - traffic_phase_ctrl_if.slave: en, mode, cfg_we/cfg_phase/cfg_green,
//           req (inputs); lamp {G,Y,R} per phase, active_phase, phase_start
// Optional feature: define TPC_DEMAND_SKIP_EN to pick the next phase by
// round-robin over req; otherwise rotation is strictly sequential.
module traffic_phase_ctrl #(
    parameter int unsigned NUM_PH   = 4,
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GREEN_T  = 50,
    parameter int unsigned YELLOW_T = 10,
    parameter int unsigned ALLRED_T = 2
) (
    input logic clk,
    input logic rst_,
    traffic_phase_ctrl_if.slave bus
);
    localparam int unsigned PH_W  = $clog2(NUM_PH);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [2:0] L_G   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_R   = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    typedef enum logic [2:0] {S_ALLRED, S_GREEN, S_YELLOW, S_FLASH, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic                first_q, first_d;     // next ALLRED exit re-serves ph_q
    logic                flash_q, flash_d;
    logic [CNT_W-1:0]    green_run_q, green_run_d;
    logic [CNT_W-1:0]    green_t_q [NUM_PH];
    logic [CNT_W-1:0]    green_t_d [NUM_PH];
    logic [3*NUM_PH-1:0] lamp_q, lamp_d;
    logic                start_q, start_d;

    logic                tick_c;
    logic                done_c;
    logic [CNT_W-1:0]    dur_c;
    logic [PH_W-1:0]     nxt_ph_c;
    logic [PH_W-1:0]     seq_ph_c;

    // Prescaler: one-cycle tick on wrap, frozen while en is low
    always_comb begin
        tick_c = bus.en && (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d  = pre_q;
        if (bus.en) begin
            pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
        end
    end

    // Duration of the current state; zero behaves as one tick
    always_comb begin
        case (state_q)
            S_ALLRED: dur_c = CNT_W'(ALLRED_T);
            S_GREEN:  dur_c = green_run_q;
            S_YELLOW: dur_c = CNT_W'(YELLOW_T);
            default:  dur_c = CNT_W'(1);
        endcase
        if (dur_c == '0) begin
            dur_c = CNT_W'(1);
        end
        done_c = tick_c && (timer_q == dur_c - CNT_W'(1));
    end

    // Next phase to serve on a normal ALLRED exit
    always_comb begin
        seq_ph_c = (ph_q == PH_W'(NUM_PH - 1)) ? '0 : ph_q + PH_W'(1);
        nxt_ph_c = seq_ph_c;
`ifdef TPC_DEMAND_SKIP_EN
        // Scan forward from ph_q+1; the last candidate is ph_q itself
        for (int unsigned i = NUM_PH; i >= 1; i--) begin
            if (bus.req[PH_W'((32'(ph_q) + i) % NUM_PH)]) begin
                nxt_ph_c = PH_W'((32'(ph_q) + i) % NUM_PH);
            end
        end
`endif
    end

`ifndef TPC_DEMAND_SKIP_EN
    logic unused_req_c;
    assign unused_req_c = ^bus.req;
`endif

    // Green-time table writes, accepted regardless of en
    always_comb begin
        green_t_d = green_t_q;
        if (bus.cfg_we && (32'(bus.cfg_phase) < NUM_PH)) begin
            green_t_d[bus.cfg_phase] = bus.cfg_green;
        end
    end

    // Next-state and phase bookkeeping
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ph_d        = ph_q;
        first_d     = first_q;
        flash_d     = flash_q;
        green_run_d = green_run_q;
        start_d     = 1'b0;
        if (bus.en) begin
            if (tick_c) begin
                timer_d = timer_q + CNT_W'(1);
            end
            case (state_q)
                S_GREEN: begin
                    if (bus.mode != 2'b00 || done_c) begin
                        state_d = S_YELLOW;
                    end
                end
                S_YELLOW: begin
                    if (done_c) begin
                        state_d = S_ALLRED;
                    end
                end
                S_ALLRED: begin
                    if (done_c) begin
                        if (bus.mode == 2'b01) begin
                            state_d = S_FLASH;
                            flash_d = 1'b1;
                        end else if (bus.mode != 2'b00) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_GREEN;
                            if (!first_q) begin
                                ph_d = nxt_ph_c;
                            end
                            first_d     = 1'b0;
                            green_run_d = green_t_q[ph_d];
                            start_d     = 1'b1;
                        end
                    end
                end
                S_FLASH, S_HOLD: begin
                    if (bus.mode == 2'b00) begin
                        state_d = S_ALLRED;
                        ph_d    = '0;
                        first_d = 1'b1;
                    end else if (bus.mode == 2'b01) begin
                        if (state_q == S_HOLD) begin
                            state_d = S_FLASH;
                            flash_d = 1'b1;
                        end else if (tick_c) begin
                            flash_d = ~flash_q;
                        end
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: state_d = S_ALLRED;
            endcase
            if (state_d != state_q || state_d == S_FLASH || state_d == S_HOLD) begin
                timer_d = '0;
            end
        end
    end

    // Lamps follow the next state so they change with the state register
    always_comb begin
        lamp_d = '0;
        for (int unsigned i = 0; i < NUM_PH; i++) begin
            case (state_d)
                S_GREEN:  lamp_d[3*i +: 3] = (ph_d == PH_W'(i)) ? L_G : L_R;
                S_YELLOW: lamp_d[3*i +: 3] = (ph_d == PH_W'(i)) ? L_Y : L_R;
                S_FLASH:  lamp_d[3*i +: 3] = flash_d ? L_Y : L_OFF;
                default:  lamp_d[3*i +: 3] = L_R;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= S_ALLRED;
            pre_q       <= '0;
            timer_q     <= '0;
            ph_q        <= '0;
            first_q     <= 1'b1;
            flash_q     <= 1'b0;
            green_run_q <= CNT_W'(GREEN_T);
            lamp_q      <= {NUM_PH{L_R}};
            start_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_PH; i++) begin
                green_t_q[i] <= CNT_W'(GREEN_T);
            end
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            timer_q     <= timer_d;
            ph_q        <= ph_d;
            first_q     <= first_d;
            flash_q     <= flash_d;
            green_run_q <= green_run_d;
            lamp_q      <= lamp_d;
            start_q     <= start_d;
            green_t_q   <= green_t_d;
        end
    end

    assign bus.lamp         = lamp_q;
    assign bus.active_phase = ph_q;
    assign bus.phase_start  = start_q;
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-phase intersection signal controller, successor to the fixed 2-direction controller. Runs a safe Green -> Yellow -> All-Red cycle per phase. Per-phase green times are runtime-loadable, and timing comes from a prescaled tick. Supports flash and all-red hold modes, each entered through a forced yellow/all-red clearance. Sits between the system timebase and the lamp drivers.

Parameters:
NUM_PH, 4, number of signal phases (2..8)
TICK_DIV, 500000, clk cycles per timing tick (>=2)
CNT_W, 8, width of duration fields and tick timer
GREEN_T, 50, reset value of every per-phase green duration (ticks)
YELLOW_T, 10, yellow duration (ticks)
ALLRED_T, 2, all-red clearance duration (ticks)

Ports:
clk  input  1  system clock, single clock domain
rst_  input  1  asynchronous active-low reset
en  input  1  global run enable; low freezes prescaler, timer and FSM
mode  input  2  00 normal, 01 flash, 10 all-red hold, 11 treated as 10
cfg_we  input  1  write strobe for green duration
cfg_phase  input  $clog2(NUM_PH)  phase index for cfg write
cfg_green  input  CNT_W  green duration in ticks
req  input  NUM_PH  per-phase demand (used only with optional feature)
lamp  output  3*NUM_PH  per phase i, bits [3i+2:3i] = {G,Y,R}; green 100, yellow 010, red 001, off 000
active_phase  output  $clog2(NUM_PH)  phase currently served
phase_start  output  1  one-cycle pulse on entry to GREEN

Behaviour:
- Reset (async): FSM=ALLRED, active_phase=0, prescaler=0, timer=0, every lamp=001, phase_start=0, all green_t[i]=GREEN_T.
- Prescaler counts 0..TICK_DIV-1 while en=1. tick=1 for one cycle when it wraps at TICK_DIV-1.
- Timer counts ticks within a state. A state of duration D exits on the tick where timer==D-1; the timer clears on every state change. D=0 is treated as 1.
- States: ALLRED, GREEN, YELLOW, FLASH, HOLD. All transitions are registered, and lamps update in the same cycle as the state change.
- Normal cycle: ALLRED(ALLRED_T) -> GREEN(green_t[active_phase]) -> YELLOW(YELLOW_T) -> ALLRED.
  - On ALLRED exit in normal mode, active_phase advances to the next phase, wrapping NUM_PH-1 -> 0.
  - Exception: the first ALLRED after reset or after mode exit serves phase 0 without advancing.
- Lamps in normal operation: only active_phase is non-red; it shows 100 in GREEN and 010 in YELLOW. All other phases show 001 at all times.
- Mode change (mode!=00):
  - Sampled every cycle.
  - In GREEN: jump to YELLOW immediately, timer cleared.
  - YELLOW and ALLRED complete normally.
  - ALLRED then exits to FLASH (mode 01) or HOLD (mode 10/11) instead of GREEN.
- FLASH: all phases toggle 010/000 each tick, starting at 010.
- HOLD: all phases 001.
- FLASH <-> HOLD switches directly.
- Mode back to 00 from FLASH/HOLD: enter ALLRED for a full ALLRED_T, with active_phase=0.
- Config write:
  - cfg_we writes green_t[cfg_phase].
  - cfg_phase>=NUM_PH is ignored.
  - A write to the currently green phase takes effect at that phase's next GREEN entry; the running duration is latched at GREEN entry.
- en=0: state, timer, prescaler and lamps hold; no phase_start. Config writes are still accepted.
- phase_start pulses in the first cycle of GREEN only.

Optional Feature:
Macro TPC_DEMAND_SKIP_EN.
- Defined: on ALLRED exit, the next phase is the first phase after active_phase (round-robin) with req bit set. If req==0, the next phase is the sequential phase +1. If only the current phase has demand, it is re-served.
- Undefined: req is ignored; strict sequential rotation.

Test Plan:
- Use NUM_PH=3, TICK_DIV=4, GREEN_T=3, YELLOW_T=2, ALLRED_T=1 for all scenarios.
1. Reset release -> all lamps 001 for 4 clk, then phase0=100 with phase_start pulse; phase0 100 for 12 clk, 010 for 8 clk, all 001 for 4 clk, then phase1=100, active_phase=1.
2. cfg_we with cfg_phase=1, cfg_green=5 during phase0 GREEN -> phase1 green lasts 20 clk; cfg_phase=3 write -> no effect.
3. mode=01 mid phase0 GREEN -> next cycle phase0=010 for 8 clk, all 001 for 4 clk, then all 010/000 alternating every 4 clk; mode=00 -> all 001 for 4 clk, then phase0=100.
4. en=0 for 10 clk mid YELLOW -> lamps frozen; YELLOW total 18 clk; no extra tick.
5. TPC_DEMAND_SKIP_EN with req=3'b100 during phase0 -> after ALLRED phase2 serves; with req=0 -> phase1 serves.
6. rst_ low mid GREEN with no clk edge -> all lamps 001 immediately, active_phase=0.
